// File: rtl/gt_bringup_pkg.sv
// Shared types and constants for the GT TX bring-up controller.
//   state_e : bring-up FSM state encoding
//   RETRY_W : width of the retry_count output
package gt_bringup_pkg;

  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_WAIT_ACTIVE = 3'd0,
    ST_BB_RESET    = 3'd1,
    ST_WAIT_DONE   = 3'd2,
    ST_READY       = 3'd3,
    ST_FAIL        = 3'd4
  } state_e;

endpackage

// File: rtl/gt_lane_gate.sv
// Per-lane output gate: forwards lane data while the link is ready, otherwise
// drives the idle fill word. Output is registered (1 cycle latency).
//   clock, reset : TX user clock, synchronous active-high reset
//   pass         : 1 = forward data_in, 0 = send IDLE_WORD
//   data_in      : lane user data
//   data_out     : registered lane data toward the wizard
module gt_lane_gate #(
  parameter int unsigned               LANE_WIDTH = 40,
  parameter logic [LANE_WIDTH-1:0]     IDLE_WORD  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pass,
  input  logic [LANE_WIDTH-1:0] data_in,
  output logic [LANE_WIDTH-1:0] data_out
);

  logic [LANE_WIDTH-1:0] data_d;
  logic [LANE_WIDTH-1:0] data_q;

  always_comb begin
    data_d = IDLE_WORD;
    if (pass) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= IDLE_WORD;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/gt_tx_bringup_ctrl.sv
// GT TX bring-up controller: sequences the user-clock helper reset, the TX
// buffer-bypass reset with bounded retries, and gates lane data until ready.
//   clock, reset          : TX usrclk2, synchronous active-high reset
//   txpmaresetdone        : per-lane PMA reset done
//   txprgdivresetdone     : per-lane prog-divider reset done
//   userclk_tx_active     : user clock helper active
//   buffbypass_tx_done    : bypass alignment done
//   buffbypass_tx_error   : bypass alignment error
//   reset_tx_done         : wizard TX reset done
//   userclk_tx_reset      : user clock helper reset (registered)
//   buffbypass_tx_reset   : bypass controller reset (registered)
//   tx_reset              : downstream datapath reset (registered)
//   tx_ready / tx_fail    : link usable / sticky failure (registered)
//   retry_count           : bypass-reset retries consumed (registered)
//   tx_data_in/out        : lane data in, gated registered data out
module gt_tx_bringup_ctrl
  import gt_bringup_pkg::*;
#(
  parameter int unsigned           LANES           = 4,
  parameter int unsigned           LANE_WIDTH      = 40,
  parameter int unsigned           BB_RESET_CYCLES = 5,
  parameter int unsigned           DONE_TIMEOUT    = 65535,
  parameter int unsigned           MAX_RETRIES     = 3,
  parameter logic [LANE_WIDTH-1:0] IDLE_WORD       = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [LANES-1:0]            txpmaresetdone,
  input  logic [LANES-1:0]            txprgdivresetdone,
  input  logic                        userclk_tx_active,
  input  logic                        buffbypass_tx_done,
  input  logic                        buffbypass_tx_error,
  input  logic                        reset_tx_done,
  output logic                        userclk_tx_reset,
  output logic                        buffbypass_tx_reset,
  output logic                        tx_reset,
  output logic                        tx_ready,
  output logic                        tx_fail,
  output logic [RETRY_W-1:0]          retry_count,
  input  logic [LANES*LANE_WIDTH-1:0] tx_data_in,
  output logic [LANES*LANE_WIDTH-1:0] tx_data_out
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned TMO_W  = 20;

  // WAIT_DONE stays for exactly DONE_TIMEOUT cycles: the timeout fires on the
  // cycle whose incremented count reaches DONE_TIMEOUT.
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(DONE_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(BB_RESET_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_e              state_d, state_q;
  logic [HOLD_W-1:0]   hold_d, hold_q;
  logic [TMO_W-1:0]    tmo_d, tmo_q;
  logic [RETRY_W-1:0]  retry_d, retry_q;
  logic                retry_take;

  logic                userclk_tx_reset_d, userclk_tx_reset_q;
  logic                buffbypass_tx_reset_d, buffbypass_tx_reset_q;
  logic                tx_reset_d, tx_reset_q;
  logic                tx_ready_d, tx_ready_q;
  logic                tx_fail_d, tx_fail_q;

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    retry_take = 1'b0;

    case (state_q)
      ST_WAIT_ACTIVE: begin
        if (userclk_tx_active) begin
          state_d = ST_BB_RESET;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_BB_RESET: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) begin
          state_d = ST_WAIT_DONE;
          tmo_d   = '0;
        end
      end
      ST_WAIT_DONE: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Error outranks done.
        if (buffbypass_tx_error || (tmo_q == TMO_LAST)) begin
          retry_take = 1'b1;
        end else if (buffbypass_tx_done && reset_tx_done) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (buffbypass_tx_error) begin
          retry_take = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_WAIT_ACTIVE;
      end
    endcase

    // retry_q < RETRY_MAX <= 15 guarantees the increment cannot wrap.
    if (retry_take) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_BB_RESET;
        hold_d  = HOLD_LOAD;
      end else begin
        state_d = ST_FAIL;
      end
    end

    // Losing the user clock restarts bring-up from any non-failed state.
    if ((state_q != ST_FAIL) && !userclk_tx_active) begin
      state_d = ST_WAIT_ACTIVE;
      retry_d = '0;
      hold_d  = '0;
      tmo_d   = '0;
    end
  end

  // Output decodes, computed for the next state so flops align with state_q.
  always_comb begin
    userclk_tx_reset_d    = !((&txpmaresetdone) && (&txprgdivresetdone));
    buffbypass_tx_reset_d = (state_d == ST_WAIT_ACTIVE) || (state_d == ST_BB_RESET);
    tx_ready_d            = (state_d == ST_READY);
    tx_fail_d             = (state_d == ST_FAIL);
    tx_reset_d            = !((state_q == ST_READY) && reset_tx_done);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q               <= ST_WAIT_ACTIVE;
      hold_q                <= '0;
      tmo_q                 <= '0;
      retry_q               <= '0;
      userclk_tx_reset_q    <= 1'b1;
      buffbypass_tx_reset_q <= 1'b1;
      tx_reset_q            <= 1'b1;
      tx_ready_q            <= 1'b0;
      tx_fail_q             <= 1'b0;
    end else begin
      state_q               <= state_d;
      hold_q                <= hold_d;
      tmo_q                 <= tmo_d;
      retry_q               <= retry_d;
      userclk_tx_reset_q    <= userclk_tx_reset_d;
      buffbypass_tx_reset_q <= buffbypass_tx_reset_d;
      tx_reset_q            <= tx_reset_d;
      tx_ready_q            <= tx_ready_d;
      tx_fail_q             <= tx_fail_d;
    end
  end

  assign userclk_tx_reset    = userclk_tx_reset_q;
  assign buffbypass_tx_reset = buffbypass_tx_reset_q;
  assign tx_reset            = tx_reset_q;
  assign tx_ready            = tx_ready_q;
  assign tx_fail             = tx_fail_q;
  assign retry_count         = retry_q;

  // Lane gates follow the registered tx_ready.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gt_lane_gate #(
      .LANE_WIDTH (LANE_WIDTH),
      .IDLE_WORD  (IDLE_WORD)
    ) u_gate (
      .clock    (clock),
      .reset    (reset),
      .pass     (tx_ready_q),
      .data_in  (tx_data_in[i*LANE_WIDTH +: LANE_WIDTH]),
      .data_out (tx_data_out[i*LANE_WIDTH +: LANE_WIDTH])
    );
  end

endmodule

// File: tb/tb_gt_tx_bringup_ctrl.sv
// Directed self-checking bench for gt_tx_bringup_ctrl.
module tb_gt_tx_bringup_ctrl;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_WIDTH = 40;
  localparam int unsigned DW         = LANES * LANE_WIDTH;
  localparam logic [LANE_WIDTH-1:0] IDLE = 40'hC3C3C3C3C3;

  logic          clock = 1'b0;
  logic          reset;
  logic [LANES-1:0] txpmaresetdone;
  logic [LANES-1:0] txprgdivresetdone;
  logic          userclk_tx_active;
  logic          buffbypass_tx_done;
  logic          buffbypass_tx_error;
  logic          reset_tx_done;
  logic          userclk_tx_reset;
  logic          buffbypass_tx_reset;
  logic          tx_reset;
  logic          tx_ready;
  logic          tx_fail;
  logic [3:0]    retry_count;
  logic [DW-1:0] tx_data_in;
  logic [DW-1:0] tx_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] idle_rep;
  logic [DW-1:0] p1;
  logic [DW-1:0] p2;

  gt_tx_bringup_ctrl #(
    .LANES           (LANES),
    .LANE_WIDTH      (LANE_WIDTH),
    .BB_RESET_CYCLES (5),
    .DONE_TIMEOUT    (20),
    .MAX_RETRIES     (3),
    .IDLE_WORD       (IDLE)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .txpmaresetdone      (txpmaresetdone),
    .txprgdivresetdone   (txprgdivresetdone),
    .userclk_tx_active   (userclk_tx_active),
    .buffbypass_tx_done  (buffbypass_tx_done),
    .buffbypass_tx_error (buffbypass_tx_error),
    .reset_tx_done       (reset_tx_done),
    .userclk_tx_reset    (userclk_tx_reset),
    .buffbypass_tx_reset (buffbypass_tx_reset),
    .tx_reset            (tx_reset),
    .tx_ready            (tx_ready),
    .tx_fail             (tx_fail),
    .retry_count         (retry_count),
    .tx_data_in          (tx_data_in),
    .tx_data_out         (tx_data_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    idle_rep = {LANES{IDLE}};
    p1 = {LANES{40'hA5A5A5A5A5}};
    p2 = {40'h0123456789, 40'hFEDCBA9876, 40'h1111111111, 40'h5A5A5A5A5A};

    reset               = 1'b1;
    txpmaresetdone      = 4'hF;
    txprgdivresetdone   = 4'hF;
    userclk_tx_active   = 1'b0;
    buffbypass_tx_done  = 1'b0;
    buffbypass_tx_error = 1'b0;
    reset_tx_done       = 1'b0;
    tx_data_in          = '0;
    step(2);

    // Reset values
    check("rst_userclk_reset", DW'(userclk_tx_reset), DW'(1));
    check("rst_bb_reset", DW'(buffbypass_tx_reset), DW'(1));
    check("rst_tx_reset", DW'(tx_reset), DW'(1));
    check("rst_ready", DW'(tx_ready), DW'(0));
    check("rst_fail", DW'(tx_fail), DW'(0));
    check("rst_retry", DW'(retry_count), DW'(0));
    check("rst_data", tx_data_out, idle_rep);

    // Lane done gating of userclk_tx_reset
    reset = 1'b0;
    step(1);
    check("uc_all_done", DW'(userclk_tx_reset), DW'(0));
    txpmaresetdone[2] = 1'b0;
    step(1);
    check("uc_lane2_clear", DW'(userclk_tx_reset), DW'(1));
    txpmaresetdone[2] = 1'b1;
    txprgdivresetdone[0] = 1'b0;
    step(1);
    check("uc_prgdiv0_clear", DW'(userclk_tx_reset), DW'(1));
    txprgdivresetdone[0] = 1'b1;
    step(1);
    check("uc_restored", DW'(userclk_tx_reset), DW'(0));
    check("wait_active_bb", DW'(buffbypass_tx_reset), DW'(1));

    // Nominal bring-up: BB_RESET holds 5 cycles
    userclk_tx_active = 1'b1;
    step(5);
    check("bb_hold_last", DW'(buffbypass_tx_reset), DW'(1));
    step(1);
    check("bb_released", DW'(buffbypass_tx_reset), DW'(0));
    check("wait_done_not_ready", DW'(tx_ready), DW'(0));
    step(4);
    buffbypass_tx_done = 1'b1;
    reset_tx_done      = 1'b1;
    step(1);
    check("ready_set", DW'(tx_ready), DW'(1));
    check("tx_reset_lag", DW'(tx_reset), DW'(1));
    check("data_idle_at_ready", tx_data_out, idle_rep);
    tx_data_in = p1;
    step(1);
    check("tx_reset_clear", DW'(tx_reset), DW'(0));
    check("data_p1", tx_data_out, p1);
    tx_data_in = p2;
    step(1);
    check("data_p2", tx_data_out, p2);

    // Error while READY takes the retry path
    buffbypass_tx_error = 1'b1;
    step(1);
    buffbypass_tx_error = 1'b0;
    check("ready_err_retry", DW'(retry_count), DW'(1));
    check("ready_err_not_ready", DW'(tx_ready), DW'(0));
    check("ready_err_bb", DW'(buffbypass_tx_reset), DW'(1));
    step(6);
    check("re_ready", DW'(tx_ready), DW'(1));

    // Active drop in READY
    userclk_tx_active = 1'b0;
    step(1);
    check("drop_ready", DW'(tx_ready), DW'(0));
    check("drop_retry", DW'(retry_count), DW'(0));
    check("drop_bb", DW'(buffbypass_tx_reset), DW'(1));
    step(1);
    check("drop_data_idle", tx_data_out, idle_rep);

    // Simultaneous error and done in WAIT_DONE
    userclk_tx_active = 1'b1;
    step(6);
    check("simul_in_wait", DW'(buffbypass_tx_reset), DW'(0));
    buffbypass_tx_error = 1'b1;
    step(1);
    buffbypass_tx_error = 1'b0;
    check("simul_not_ready", DW'(tx_ready), DW'(0));
    check("simul_retry", DW'(retry_count), DW'(1));
    check("simul_bb", DW'(buffbypass_tx_reset), DW'(1));

    // Timeout after exactly 20 WAIT_DONE cycles
    buffbypass_tx_done = 1'b0;
    step(5);
    check("tmo_enter_wait", DW'(buffbypass_tx_reset), DW'(0));
    step(19);
    check("tmo_still_wait", DW'(buffbypass_tx_reset), DW'(0));
    check("tmo_retry_before", DW'(retry_count), DW'(1));
    step(1);
    check("tmo_bb_reassert", DW'(buffbypass_tx_reset), DW'(1));
    check("tmo_retry_after", DW'(retry_count), DW'(2));
    step(4);
    check("tmo_bb_hold5", DW'(buffbypass_tx_reset), DW'(1));
    step(1);
    check("tmo_bb_release", DW'(buffbypass_tx_reset), DW'(0));

    // Remaining retries exhausted -> FAIL
    buffbypass_tx_error = 1'b1;
    step(1);
    buffbypass_tx_error = 1'b0;
    check("err_retry3", DW'(retry_count), DW'(3));
    check("err_not_fail_yet", DW'(tx_fail), DW'(0));
    step(5);
    buffbypass_tx_error = 1'b1;
    step(1);
    buffbypass_tx_error = 1'b0;
    check("fail_set", DW'(tx_fail), DW'(1));
    check("fail_retry_sat", DW'(retry_count), DW'(3));
    check("fail_bb", DW'(buffbypass_tx_reset), DW'(0));

    // FAIL is sticky, even against active drop and done
    userclk_tx_active  = 1'b0;
    buffbypass_tx_done = 1'b1;
    step(3);
    check("fail_sticky", DW'(tx_fail), DW'(1));
    check("fail_sticky_ready", DW'(tx_ready), DW'(0));
    check("fail_sticky_retry", DW'(retry_count), DW'(3));

    // Reset clears FAIL
    reset = 1'b1;
    step(1);
    check("rst_fail_clear", DW'(tx_fail), DW'(0));
    check("rst_retry_clear", DW'(retry_count), DW'(0));
    check("rst_bb_set", DW'(buffbypass_tx_reset), DW'(1));
    check("rst_data_idle", tx_data_out, idle_rep);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
